shift_out_8_bit: RTL

Parallel-in, serial-out transmitter that reads an 8-bit word from the Q bus of a register_8_bit stage and sends it one bit per accepted beat over a valid/ready serial link. It is the read-side counterpart of the 8-bit storage registers in the multiply-accumulate datapath and moves operands and accumulated results off-block one bit at a time. It contains a shift register, a bit counter and a three-state controller.

---
 rtl/shift_out_8_bit.sv | 98 +++++++++
 1 files changed

// File: rtl/shift_out_8_bit.sv
// Parallel-in, serial-out transmitter: captures an 8-bit word on LOAD and
// sends it one bit per valid/ready handshake, pulsing DONE after the last bit.
module shift_out_8_bit #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] In,
    input  logic       LOAD,
    output logic       READY,
    output logic       S_OUT,
    output logic       S_VALID,
    input  logic       S_READY,
    output logic       DONE
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   sr, sr_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                ready_nxt;
    logic                s_out_nxt;
    logic                s_valid_nxt;
    logic                done_nxt;

    // Next-state logic; outputs are decoded from the next state so they can be registered.
    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        cnt_nxt     = cnt;
        ready_nxt   = 1'b0;
        s_out_nxt   = 1'b0;
        s_valid_nxt = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (LOAD) begin
                    sr_nxt    = In;
                    cnt_nxt   = CNT_W'(0);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (S_READY) begin
                    sr_nxt  = LSB_FIRST ? {1'b0, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], 1'b0};
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt   = (state_nxt == IDLE);
        s_valid_nxt = (state_nxt == SHIFT);
        done_nxt    = (state_nxt == FINISH);
        if (state_nxt == SHIFT) begin
            s_out_nxt = LSB_FIRST ? sr_nxt[0] : sr_nxt[DATA_W-1];
        end
    end

    // State, datapath and registered outputs; reset wins over every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            READY   <= 1'b1;
            S_OUT   <= 1'b0;
            S_VALID <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            cnt     <= cnt_nxt;
            READY   <= ready_nxt;
            S_OUT   <= s_out_nxt;
            S_VALID <= s_valid_nxt;
            DONE    <= done_nxt;
        end
    end

endmodule
